// File: rtl/d_ff.sv
// Positive-edge D flip-flop with synchronous active-high reset.
// WIDTH bits of storage; rst loads RESET_VALUE, otherwise q follows d one clock later.
`timescale 1ns/1ps

module d_ff #(
  parameter int unsigned            WIDTH       = 1,
  parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  // Reset is checked first so it wins over d on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: a 1-bit default instance on the main timeline and an
// 8-bit instance with a non-zero reset value, checked at fixed times.
`timescale 1ns/1ps

module tb_d_ff;

  logic       clk;
  logic       rst;
  logic       d;
  logic       q;
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [7:0] exp_q[$];

  d_ff u_dut (
    .d   (d),
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  d_ff #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .d   (d8),
    .clk (clk),
    .rst (rst8),
    .q   (q8)
  );

  // Rising edges at 10, 30, 50, ...; falling edges at 20, 40, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic at_time(input longint unsigned t);
    if (t > $time) #(t - $time);
  endtask

  task automatic drive(input logic r, input logic v);
    rst = r;
    d   = v;
  endtask

  task automatic drive8(input logic r, input logic [7:0] v);
    rst8 = r;
    d8   = v;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pops the next hand-computed 8-bit expectation and compares it with q8.
  task automatic check8(input string tag);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: expected queue empty, observed %h", tag, q8);
    end else begin
      exp = exp_q.pop_front();
      check(tag, q8, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    drive(1'b1, 1'b0);
    drive8(1'b1, 8'h00);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);

    at_time(11);  check("reset_first_edge", {7'd0, q}, 8'h00);
    check8("w8_reset_value");
    at_time(51);  check("reset_hold_50", {7'd0, q}, 8'h00);
    at_time(91);  check("reset_hold_90", {7'd0, q}, 8'h00);
    check8("w8_reset_hold");

    at_time(100); drive(1'b0, 1'b1); drive8(1'b0, 8'h3C);
    at_time(101); check("no_comb_path_d", {7'd0, q}, 8'h00);
    at_time(111); check("load_one", {7'd0, q}, 8'h01);
    check8("w8_load_3c");
    at_time(191); check("hold_one", {7'd0, q}, 8'h01);

    at_time(200); drive(1'b0, 1'b0); drive8(1'b0, 8'hC3);
    at_time(201); check("pre_edge_d0", {7'd0, q}, 8'h01);
    at_time(211); check("load_zero", {7'd0, q}, 8'h00);
    check8("w8_load_c3");

    at_time(300); drive(1'b0, 1'b1); drive8(1'b1, 8'hFF);
    at_time(311); check("reload_one", {7'd0, q}, 8'h01);
    check8("w8_reset_over_d");
    at_time(320); drive8(1'b0, 8'h5A);
    at_time(331); check8("w8_after_release");
    at_time(549); check("hold_until_550", {7'd0, q}, 8'h01);

    // Reset asserted mid-cycle while d stays 1.
    at_time(560); drive(1'b1, 1'b1);
    at_time(561); check("rst_no_async", {7'd0, q}, 8'h01);
    at_time(571); check("rst_first_edge", {7'd0, q}, 8'h00);
    at_time(591); check("rst_held", {7'd0, q}, 8'h00);
    at_time(600); drive(1'b0, 1'b1);
    at_time(601); check("rst_release_wait", {7'd0, q}, 8'h00);
    at_time(611); check("rst_release_load", {7'd0, q}, 8'h01);

    // d toggles between the 610 and 630 edges; only the last value counts.
    at_time(615); drive(1'b0, 1'b0);
    at_time(618); drive(1'b0, 1'b1);
    at_time(622); drive(1'b0, 1'b0);
    at_time(626); check("toggle_no_glitch", {7'd0, q}, 8'h01);
    at_time(631); check("toggle_last_value", {7'd0, q}, 8'h00);

    at_time(660);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
